// File: rtl/sharedmemory.sv
// Shared defaults and helpers for the banked ring buffer RAM.
package sharedmemory;

  localparam int unsigned DEF_NO_BANKS      = 4;
  localparam int unsigned DEF_WORD_WIDTH    = 16;
  localparam int unsigned DEF_ADDRESS_WIDTH = 10;

  // Bank index width; never narrower than one bit.
  function automatic int unsigned bank_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unitRAM.sv
// Single RAM bank: one write port and one registered read port.
module unitRAM #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [WORD_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [WORD_WIDTH-1:0]    rdata
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] rdata_q;

  // Read register holds its value between reads; no reset so it maps to RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bank_ring_ram.sv
// Ring of RAM banks: writer fills banks in order, reader consumes and releases whole banks.
module bank_ring_ram
  import sharedmemory::*;
#(
  parameter int unsigned NO_BANKS      = DEF_NO_BANKS,
  parameter int unsigned WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_valid,
  input  logic [WORD_WIDTH-1:0]              wr_data,
  output logic                               wr_ready,
  output logic                               overflow,
  output logic                               rd_bank_valid,
  output logic [bank_idx_w(NO_BANKS)-1:0]    rd_bank_id,
  input  logic                               rd_en,
  input  logic [ADDRESS_WIDTH-1:0]           rd_address,
  output logic [WORD_WIDTH-1:0]              rd_data,
  output logic                               rd_data_valid,
  input  logic                               rd_release,
  output logic [$clog2(NO_BANKS+1)-1:0]      full_count
);

  localparam int unsigned BW = bank_idx_w(NO_BANKS);
  localparam int unsigned FW = $clog2(NO_BANKS + 1);

  logic [BW-1:0]            wr_bank_q, wr_bank_d;
  logic [BW-1:0]            rd_bank_q, rd_bank_d;
  logic [BW-1:0]            rd_sel_q, rd_sel_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [FW-1:0]            full_count_q, full_count_d;
  logic                     overflow_q, overflow_d;
  logic                     rd_data_valid_q, rd_data_valid_d;
  logic                     rd_seen_q, rd_seen_d;

  logic                     wr_accept, rd_accept, rel_accept, bank_done;
  logic [NO_BANKS-1:0]      wr_onehot, rd_onehot;
  logic [WORD_WIDTH-1:0]    bank_rdata [NO_BANKS];

  function automatic logic [BW-1:0] bump(input logic [BW-1:0] p);
    return (p == BW'(NO_BANKS - 1)) ? '0 : p + BW'(1);
  endfunction

  assign wr_ready      = (full_count_q != FW'(NO_BANKS));
  assign rd_bank_valid = (full_count_q != '0);
  assign rd_bank_id    = rd_bank_q;
  assign full_count    = full_count_q;
  assign overflow      = overflow_q;
  assign rd_data_valid = rd_data_valid_q;

  assign wr_accept  = wr_valid && wr_ready;
  assign rd_accept  = rd_en && rd_bank_valid;
  assign rel_accept = rd_release && rd_bank_valid;
  assign bank_done  = wr_accept && (&wr_addr_q);
  assign wr_onehot  = NO_BANKS'(1) << wr_bank_q;
  assign rd_onehot  = NO_BANKS'(1) << rd_bank_q;

  // Until the first read after reset the output reads as zero.
  assign rd_data = rd_seen_q ? bank_rdata[rd_sel_q] : '0;

  // Next-state for pointers, occupancy and read-side status.
  always_comb begin
    wr_bank_d       = wr_bank_q;
    wr_addr_d       = wr_addr_q;
    rd_bank_d       = rd_bank_q;
    rd_sel_d        = rd_sel_q;
    full_count_d    = full_count_q;
    rd_seen_d       = rd_seen_q;
    overflow_d      = wr_valid && !wr_ready;
    rd_data_valid_d = rd_accept;

    if (wr_accept) wr_addr_d = wr_addr_q + ADDRESS_WIDTH'(1);
    if (bank_done) wr_bank_d = bump(wr_bank_q);
    if (rel_accept) rd_bank_d = bump(rd_bank_q);
    if (rd_accept) begin
      rd_sel_d  = rd_bank_q;
      rd_seen_d = 1'b1;
    end

    // Completion and release in the same cycle cancel out.
    if (bank_done && !rel_accept)      full_count_d = full_count_q + FW'(1);
    else if (!bank_done && rel_accept) full_count_d = full_count_q - FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q       <= '0;
      wr_addr_q       <= '0;
      rd_bank_q       <= '0;
      rd_sel_q        <= '0;
      full_count_q    <= '0;
      overflow_q      <= 1'b0;
      rd_data_valid_q <= 1'b0;
      rd_seen_q       <= 1'b0;
    end else begin
      wr_bank_q       <= wr_bank_d;
      wr_addr_q       <= wr_addr_d;
      rd_bank_q       <= rd_bank_d;
      rd_sel_q        <= rd_sel_d;
      full_count_q    <= full_count_d;
      overflow_q      <= overflow_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_seen_q       <= rd_seen_d;
    end
  end

  for (genvar i = 0; i < NO_BANKS; i++) begin : g_bank
    unitRAM #(
      .WORD_WIDTH    (WORD_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (wr_accept && !rst && wr_onehot[i]),
      .waddr (wr_addr_q),
      .wdata (wr_data),
      .re    (rd_accept && !rst && rd_onehot[i]),
      .raddr (rd_address),
      .rdata (bank_rdata[i])
    );
  end

endmodule

// File: doc/bank_ring_ram.md
BANK_RING_RAM -- requirements
Module: bank_ring_ram

Interface
REQ-001 SHALL have parameter NO_BANKS, default 4, number of banks (legal range 2..16).
REQ-002 SHALL have parameter WORD_WIDTH, default 16, data word width in bits.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 10, per-bank address width; bank depth is DEPTH = 2**ADDRESS_WIDTH.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port wr_valid, input, 1, write word present.
REQ-007 SHALL have port wr_data, input, WORD_WIDTH, write word.
REQ-008 SHALL have port wr_ready, output, 1, write bank available.
REQ-009 SHALL have port overflow, output, 1, one-cycle pulse when a word is dropped.
REQ-010 SHALL have port rd_bank_valid, input-side status output, 1, a full bank is available to the reader.
REQ-011 SHALL have port rd_bank_id, output, clog2(NO_BANKS), index of the bank currently presented to the reader.
REQ-012 SHALL have port rd_en, input, 1, read request.
REQ-013 SHALL have port rd_address, input, ADDRESS_WIDTH, word address within the presented bank.
REQ-014 SHALL have port rd_data, output, WORD_WIDTH, read word.
REQ-015 SHALL have port rd_data_valid, output, 1, rd_data updated this cycle.
REQ-016 SHALL have port rd_release, input, 1, reader finished with the presented bank.
REQ-017 SHALL have port full_count, output, clog2(NO_BANKS+1), number of full, unreleased banks.

Function
REQ-018 SHALL keep a write bank pointer wr_bank, write address wr_addr, read bank pointer rd_bank and counter full_count; both pointers wrap NO_BANKS-1 -> 0.
REQ-019 SHALL drive wr_ready = (full_count != NO_BANKS), combinationally.
REQ-020 SHALL, on wr_valid && wr_ready, write wr_data to bank wr_bank at wr_addr, then increment wr_addr.
REQ-021 SHALL, when a write is accepted at wr_addr == DEPTH-1, wrap wr_addr to 0, advance wr_bank, and increment full_count.
REQ-022 SHALL, on wr_valid && !wr_ready, drop the word, leave all pointers unchanged, and pulse overflow high for exactly that next cycle.
REQ-023 SHALL drive rd_bank_valid = (full_count != 0) and rd_bank_id = rd_bank.
REQ-024 SHALL, on rd_en && rd_bank_valid, present the word at bank rd_bank, rd_address on rd_data one cycle later, with rd_data_valid high for that cycle.
REQ-025 SHALL ignore rd_en while rd_bank_valid is low: rd_data holds and rd_data_valid is low.
REQ-026 SHALL hold rd_data at its last value when no read is issued.
REQ-027 SHALL, on rd_release && rd_bank_valid, advance rd_bank and decrement full_count; a read issued in the same cycle still uses the pre-release bank.
REQ-028 SHALL ignore rd_release while rd_bank_valid is low.
REQ-029 SHALL, on simultaneous bank completion (REQ-021) and release (REQ-027), leave full_count unchanged while both pointers advance.
REQ-030 SHALL never write to a bank counted in full_count; the bank under read is never written.
REQ-031 SHALL gate each bank's write enable with a one-hot decode of wr_bank and select rd_data through a mux indexed by the registered rd_bank; there is no fixed-width case decode.

Reset
REQ-032 SHALL, on rst high at a clock edge, set wr_bank=0, wr_addr=0, rd_bank=0, full_count=0, rd_data=0, rd_data_valid=0, overflow=0; RAM contents are not cleared.
REQ-033 SHALL discard a partially filled bank on reset mid-frame; the next accepted word lands at bank 0, address 0.
REQ-034 SHALL take rst precedence over every concurrent write, read or release.

Structure
REQ-035 SHALL place the default parameter values and the bank-index width function in the shared sharedmemory package.
REQ-036 SHALL instantiate unitRAM (single-bank, one write port, one registered read port) once per bank via generate loop.

Verification
REQ-037 SHALL cover, with NO_BANKS=2, ADDRESS_WIDTH=2: write 0..3 -> after 4th accept full_count=1, rd_bank_valid=1, rd_bank_id=0, wr_bank=1.
REQ-038 SHALL cover a read of address 2 after REQ-037 -> rd_data=2 with rd_data_valid one cycle after rd_en.
REQ-039 SHALL cover writing 8 words with no release, then a 9th -> wr_ready=0 after the 8th, 9th dropped, overflow pulsed once, full_count=2.
REQ-040 SHALL cover a release in the same cycle as the 4th write of the next bank -> full_count unchanged, rd_bank_id 0->1.
REQ-041 SHALL cover rst after 2 words into a bank -> all outputs at reset values; next 4 writes fill bank 0 from address 0.
REQ-042 SHALL cover rd_en and rd_release while rd_bank_valid=0 -> no state change, rd_data_valid=0.
